// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - bus-strobe micro-sequencer for the shared-bus ALU
module alu_sequencer #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [REG_AW-1:0] instr_rt,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [DATA_W-1:0] instr_imm,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [REG_AW-1:0] regSel,
    output logic              regOutEn,
    output logic              regWrEn,
    output logic              immOutEn,
    output logic [DATA_W-1:0] immData,
    output logic              enIn1,
    output logic              enIn2,
    output logic [3:0]        opCode,
    output logic              outEn
);

    typedef enum logic [2:0] {IDLE, DRV1, LAT1, DRV2, LAT2, EXEC, WB, DONE} state_t;

    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_SUBI = 4'd8;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] EXEC_LD = 4'(EXEC_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;

    logic              accept;
    logic [3:0]        op_n;
    logic [REG_AW-1:0] rs_n;
    logic              imm_op;

    logic              busy_d, done_d, illegal_d, reg_out_d, reg_wr_d, imm_out_d;
    logic              en1_d, en2_d, out_en_d;
    logic [REG_AW-1:0] sel_d;

    always_comb begin
        accept = (state_q == IDLE) && start;
        op_n   = accept ? instr_op : opCode;
        rs_n   = accept ? instr_rs : rs_q;
        imm_op = (op_n == OP_ADDI) || (op_n == OP_SUBI);

        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (instr_op > OP_MAX) ? DONE : DRV1;
            DRV1: state_d = LAT1;
            LAT1: state_d = (op_n == OP_NOT) ? EXEC : DRV2;
            DRV2: state_d = LAT2;
            LAT2: state_d = EXEC;
            EXEC: if (cnt_q <= 4'd1) state_d = WB;
            WB:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // counter loads on entry to EXEC and counts down while there
        cnt_d = cnt_q;
        if (state_d == EXEC && state_q != EXEC) cnt_d = EXEC_LD;
        else if (state_q == EXEC && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;

        // outputs are decoded from the next state so they register in step with it
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        illegal_d = (state_d == DONE) && (state_q == IDLE);
        en1_d     = (state_d == LAT1);
        en2_d     = (state_d == LAT2);
        out_en_d  = (state_d == EXEC) || (state_d == WB);
        reg_wr_d  = (state_d == WB);
        reg_out_d = 1'b0;
        imm_out_d = 1'b0;
        sel_d     = '0;
        case (state_d)
            DRV1, LAT1: begin
                reg_out_d = 1'b1;
                sel_d     = rs_n;
            end
            DRV2, LAT2: begin
                if (imm_op) begin
                    imm_out_d = 1'b1;
                end else begin
                    reg_out_d = 1'b1;
                    sel_d     = rt_q;
                end
            end
            WB: sel_d = rd_q;
            default: sel_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            regSel   <= '0;
            regOutEn <= 1'b0;
            regWrEn  <= 1'b0;
            immOutEn <= 1'b0;
            immData  <= '0;
            enIn1    <= 1'b0;
            enIn2    <= 1'b0;
            opCode   <= '0;
            outEn    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            illegal  <= illegal_d;
            regSel   <= sel_d;
            regOutEn <= reg_out_d;
            regWrEn  <= reg_wr_d;
            immOutEn <= imm_out_d;
            enIn1    <= en1_d;
            enIn2    <= en2_d;
            outEn    <= out_en_d;
            if (accept) begin
                rs_q    <= instr_rs;
                rt_q    <= instr_rt;
                rd_q    <= instr_rd;
                opCode  <= instr_op;
                immData <= instr_imm;
            end
        end
    end

endmodule
